// File: rtl/aes_engine_sched.sv
// aes_engine_sched: job sequencer for the AES HWPE engine (load, rounds, emit, done).
// Optional build macro AES_SCHED_PERF_EN adds saturating cycle/stall counters.
`default_nettype none

module aes_engine_sched #(
  parameter int CNT_W = 16,
  parameter int RND_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] nb_blocks_i,
  input  logic [RND_W-1:0] nr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             eng_load_o,
  output logic             eng_round_en_o,
  output logic [RND_W-1:0] eng_round_o,
  output logic             eng_last_round_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] blk_cnt_o
`ifdef AES_SCHED_PERF_EN
  ,
  output logic [31:0]      cyc_cnt_o,
  output logic [31:0]      stall_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] nb_q, blk_cnt_q, blk_cnt_inc;
  logic [RND_W-1:0] nr_q, round_q;
  logic             err_q;
  logic             nr_legal, start_acc, load_hs, emit_hs, last_round;

  assign nr_legal    = (nr_i == RND_W'(10)) || (nr_i == RND_W'(12)) || (nr_i == RND_W'(14));
  assign start_acc   = (state == S_IDLE) && start_i && !clear_i;
  assign load_hs     = (state == S_LOAD) && in_valid_i;
  assign emit_hs     = (state == S_EMIT) && out_ready_i;
  assign last_round  = (round_q == nr_q);
  assign blk_cnt_inc = blk_cnt_q + CNT_W'(1);
  assign blk_cnt_o   = blk_cnt_q;

  always_comb begin
    state_nxt        = state;
    in_ready_o       = 1'b0;
    eng_load_o       = 1'b0;
    eng_round_en_o   = 1'b0;
    eng_round_o      = '0;
    eng_last_round_o = 1'b0;
    out_valid_o      = 1'b0;
    done_o           = 1'b0;
    err_o            = 1'b0;
    busy_o           = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (!nr_legal || (nb_blocks_i == '0)) state_nxt = S_DONE;
          else                                  state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready_o = 1'b1;
        eng_load_o = in_valid_i;
        if (in_valid_i) state_nxt = S_ROUND;
      end
      S_ROUND: begin
        eng_round_en_o   = 1'b1;
        eng_round_o      = round_q;
        eng_last_round_o = last_round;
        if (last_round) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = (blk_cnt_inc == nb_q) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done_o    = 1'b1;
        err_o     = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clear_i) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      nb_q      <= '0;
      nr_q      <= '0;
      round_q   <= '0;
      err_q     <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (clear_i) begin
        round_q   <= '0;
        err_q     <= 1'b0;
        blk_cnt_q <= '0;
      end else begin
        if (start_acc) begin
          nb_q      <= nb_blocks_i;
          nr_q      <= nr_i;
          err_q     <= !nr_legal;
          blk_cnt_q <= '0;
        end
        if (load_hs) round_q <= RND_W'(1);
        else if ((state == S_ROUND) && !last_round) round_q <= round_q + RND_W'(1);
        if (emit_hs) blk_cnt_q <= blk_cnt_inc;
      end
    end
  end

`ifdef AES_SCHED_PERF_EN
  logic stall_now;
  assign stall_now = ((state == S_LOAD) && !in_valid_i) || ((state == S_EMIT) && !out_ready_i);

  // Counters freeze at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || start_acc) begin
      cyc_cnt_o   <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (busy_o && (cyc_cnt_o != '1))      cyc_cnt_o   <= cyc_cnt_o + 32'd1;
      if (stall_now && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/aes_engine_sched.md
Name: aes_engine_sched

Overview:
Sequencing controller for the AES HWPE engine. It accepts a job (block count, round count) from the control/register side and gates the engine's input stream. Per block it steps the engine through its rounds and holds the result until the output stream accepts it. It reports busy, done and error status back to the control side.

Parameters:
CNT_W, 16, width of block-count input and block counter
RND_W, 4, width of round number/index signals

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
start_i  input  1  job start pulse; sampled only in IDLE
clear_i  input  1  soft abort; returns to IDLE
nb_blocks_i  input  CNT_W  blocks in job; latched on accepted start
nr_i  input  RND_W  rounds per block (legal: 10, 12, 14); latched on accepted start
in_valid_i  input  1  input block (a stream) valid
in_ready_o  output  1  input block accepted when in_valid_i & in_ready_o
eng_load_o  output  1  engine loads input block and does initial key add
eng_round_en_o  output  1  engine executes one round this cycle
eng_round_o  output  RND_W  current round index, 1..nr
eng_last_round_o  output  1  current round is final (no MixColumns)
out_valid_o  output  1  result block (d stream) valid
out_ready_i  input  1  downstream ready
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse at job end
err_o  output  1  one-cycle pulse, concurrent with done_o, on illegal nr
blk_cnt_o  output  CNT_W  blocks emitted in current/last job

Behaviour:
- Reset (rst_i=1 at clock edge): state IDLE. All outputs 0. Latched nb/nr and round counter cleared.
- States: IDLE, LOAD, ROUND, EMIT, DONE.
- IDLE, start_i=1:
  - If nr_i is not 10/12/14: go to DONE with err flag set.
  - Else if nb_blocks_i==0: go to DONE.
  - Else: go to LOAD.
  - In all three cases: latch nb/nr and clear blk_cnt_o to 0.
- LOAD: in_ready_o=1; eng_load_o = in_valid_i (combinational, same cycle). On handshake, go to ROUND with round=1. Otherwise stay in LOAD.
- ROUND: eng_round_en_o=1; eng_round_o=round; eng_last_round_o=(round==nr). Round increments each cycle; after round==nr go to EMIT. Rounds never stall.
- EMIT: out_valid_o=1, held stable until out_ready_i. On handshake, blk_cnt_o increments. If the new count == nb, go to DONE; else go to LOAD.
- DONE: done_o=1 (err_o=1 if err flag), one cycle, then IDLE. blk_cnt_o holds until the next accepted start.
- Minimum per-block latency with no stalls: nr+2 cycles (1 LOAD, nr ROUND, 1 EMIT).
- Back-to-back blocks: EMIT->LOAD costs no extra cycle.
- start_i outside IDLE: ignored; no effect on latched values.
- clear_i: highest priority after reset. Any state goes to IDLE at the next edge.
  - No done_o/err_o pulse.
  - blk_cnt_o cleared.
  - A partially processed block is discarded.
  - start_i and clear_i together in IDLE: clear wins; job not started.
- Counter arithmetic unsigned. blk_cnt_o cannot wrap because it terminates at nb ≤ 2^CNT_W-1.
- All outputs except eng_load_o are functions of registered state only.

Optional Feature:
AES_SCHED_PERF_EN
- Defined: adds ports cyc_cnt_o (output, 32) and stall_cnt_o (output, 32).
  - Both clear on accepted start.
  - cyc_cnt_o counts every cycle with busy_o=1.
  - stall_cnt_o counts cycles in LOAD with in_valid_i=0, plus cycles in EMIT with out_ready_i=0.
  - Both saturate at all-ones; values hold in IDLE.
  - clear_i and reset zero them.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, start_i at cycle 0 with nb=1, nr=10; in_valid_i=1, out_ready_i=1 -> LOAD cycle 1 (eng_load_o=1); eng_round_o 1..10 on cycles 2..11 with last_round on cycle 11; out_valid_o cycle 12; done_o cycle 13; blk_cnt_o=1; err_o=0.
- nb=3, nr=14, out_ready_i low for 5 cycles during block 2's EMIT -> out_valid_o held 6 cycles, no round activity; blk_cnt_o steps 1,2,3; single done_o; 3 eng_load_o pulses.
- nb=0, nr=12 -> done_o at cycle 1 after start; in_ready_o never asserted; blk_cnt_o=0.
- nr=7 -> done_o and err_o both pulse at cycle 1; no engine activity.
- start_i during ROUND ignored (round sequence unchanged); clear_i at round 5 of block 1 with nb=2 -> busy_o=0 next cycle, no done_o, blk_cnt_o=0; new start then completes normally.
- With AES_SCHED_PERF_EN, scenario 1 -> cyc_cnt_o=13, stall_cnt_o=0; with in_valid_i delayed 4 cycles -> stall_cnt_o=4, cyc_cnt_o=17.
